maze_player_ctrl: RTL and testbench
===================================

MAZE_PLAYER_CTRL -- requirements
Module: maze_player_ctrl

Interface
REQ-001 Parameter COLS, default 20: maze width in cells (640 px / 32 px cells).
REQ-002 Parameter ROWS, default 15: maze height in cells (480 px / 32 px cells).
REQ-003 Parameters START_X = 1 and START_Y = 1: player reset cell.
REQ-004 Parameters GOAL_X = 18 and GOAL_Y = 13: winning cell.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1: 50 MHz system clock (board MAX10_CLK1_50).
REQ-007 rst_n  in  1: asynchronous active-low reset (board KEY[0]).
REQ-008 frame_tick  in  1: one-cycle pulse per video frame, driven by the VGA timing stage at vertical-blank start.
REQ-009 dir_sw  in  4: raw slide switches; [3] up, [2] down, [1] left, [0] right; asynchronous to clk.
REQ-010 wall_rd  out  1: one-cycle read strobe to the maze ROM.
REQ-011 wall_x  out  5 and wall_y  out  4: cell address of the ROM read; both held stable until the response is captured.
REQ-012 wall_q  in  1: ROM data, valid exactly 1 cycle after wall_rd; 1 = wall.
REQ-013 player_x  out  5 and player_y  out  4: current player cell; consumed by the pixel renderer.
REQ-014 busy  out  1: high whenever the FSM is not in IDLE or WON.
REQ-015 win  out  1: high while the player is on the goal cell.
REQ-016 moves  out  10: count of accepted moves.

Function
REQ-017 dir_sw SHALL pass through a 2-flop synchronizer before any use.
REQ-018 FSM states: IDLE, LOOKUP, WAIT, CHECK, WON.
REQ-019 IDLE SHALL do nothing until frame_tick; on frame_tick it latches the synchronized switches and selects one direction with priority up > down > left > right.
REQ-020 If no switch is set, the FSM SHALL stay in IDLE.
REQ-021 The target cell is computed as follows: up y-1, down y+1, left x-1, right x+1.
REQ-022 If the target is outside the grid (x<0, x>=COLS, y<0, y>=ROWS), the request SHALL be dropped and the FSM SHALL stay in IDLE; the target computation uses one extra sign bit and SHALL never wrap.
REQ-023 For an in-range target, the FSM SHALL go to LOOKUP, drive wall_x/wall_y to the target, and assert wall_rd for exactly that one cycle.
REQ-024 From LOOKUP the FSM SHALL go to WAIT and then to CHECK; CHECK captures wall_q, which arrives 1 cycle after wall_rd.
REQ-025 In CHECK: if wall_q=0, player_x/player_y SHALL take the target and moves SHALL increment, saturating at 1023; if wall_q=1, the position and moves SHALL stay unchanged.
REQ-026 After CHECK, the FSM SHALL go to WON if the new position equals (GOAL_X, GOAL_Y), otherwise to IDLE.
REQ-027 Latency: the position SHALL update in the 4th clk after frame_tick (IDLE -> LOOKUP -> WAIT -> CHECK -> register).
REQ-028 A frame_tick arriving while busy or in WON SHALL be ignored; it is not queued.
REQ-029 At most one move SHALL be made per frame.
REQ-030 In WON, win SHALL be 1, position SHALL be frozen, wall_rd SHALL be 0, and the FSM SHALL leave WON only on reset.
REQ-031 A switch change during LOOKUP, WAIT or CHECK SHALL NOT affect the move in flight.

Reset
REQ-032 While rst_n=0 the block SHALL asynchronously force: FSM to IDLE, player_x=START_X, player_y=START_Y, moves=0, win=0, busy=0, wall_rd=0, wall_x=0, wall_y=0, and synchronizer flops to 0.
REQ-033 Reset asserted mid-move SHALL abort the lookup with no position update; a late wall_q SHALL be ignored.
REQ-034 Reset deassertion SHALL be synchronized to clk by the top level; the block itself needs no internal deassertion logic.

Structure
REQ-035 A shared package maze_pkg SHALL hold the FSM state encoding, the direction encoding, and the cell-size and grid constants (CELL_PX=32, COLS, ROWS), all shared with the renderer and the maze ROM.
REQ-036 One sub-module sync2, a 2-flop synchronizer of parameterized width, SHALL be instantiated for dir_sw.
REQ-037 The maze ROM SHALL be outside this block.

Verification
REQ-038 Reset, then release -> player=(1,1), moves=0, win=0, busy=0, wall_rd=0.
REQ-039 dir_sw=4'b1000 (up) at (1,1), ROM returns wall_q=1 for (1,0) -> one wall_rd with addr (1,0), 4 cycles after frame_tick position still (1,1), moves=0.
REQ-040 dir_sw=4'b0001 (right), ROM all zeros, 3 frame_ticks -> position (4,1), moves=3, exactly 3 wall_rd pulses.
REQ-041 Player at (19,5) with right pressed, then at (0,5) with left pressed -> no wall_rd, position unchanged, busy stays 0.
REQ-042 dir_sw=4'b1111 -> up chosen; extra frame_tick 2 cycles after the first -> ignored, single move.
REQ-043 Reach (18,13) -> win=1 and FSM in WON; further ticks make no moves; rst_n pulse mid-LOOKUP -> position (1,1), win=0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze definitions: grid geometry, FSM state and direction encodings.
// Also used by the pixel renderer and the maze ROM so all three agree on cell addressing.
package maze_pkg;

  localparam int CELL_PX = 32;
  localparam int COLS    = 640 / CELL_PX;
  localparam int ROWS    = 480 / CELL_PX;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WON    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  // Switch order is {up, down, left, right}; the highest set bit wins.
  function automatic dir_t pick_dir(input logic [3:0] sw);
    dir_t d;
    if (sw[3])      d = DIR_UP;
    else if (sw[2]) d = DIR_DOWN;
    else if (sw[1]) d = DIR_LEFT;
    else if (sw[0]) d = DIR_RIGHT;
    else            d = DIR_NONE;
    return d;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for quasi-static inputs; 2 cycles latency, no flow control.
// Each bit is synchronized independently, so multi-bit values may be seen mixed for one cycle.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/maze_player_ctrl.sv
// Player movement FSM: one wall-checked move per frame, position updates 4 clocks after frame_tick.
// Ticks arriving while a move is in flight or after the goal is reached are dropped, never queued.
module maze_player_ctrl #(
  parameter int COLS    = maze_pkg::COLS,
  parameter int ROWS    = maze_pkg::ROWS,
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int GOAL_X  = 18,
  parameter int GOAL_Y  = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [3:0] dir_sw,
  output logic       wall_rd,
  output logic [4:0] wall_x,
  output logic [3:0] wall_y,
  input  logic       wall_q,
  output logic [4:0] player_x,
  output logic [3:0] player_y,
  output logic       busy,
  output logic       win,
  output logic [9:0] moves
);

  import maze_pkg::*;

  state_t      state_q;
  logic [4:0]  px_q;
  logic [3:0]  py_q;
  logic [9:0]  moves_q;
  logic        win_q;
  logic        busy_q;
  logic        wall_rd_q;
  logic [4:0]  wall_x_q;
  logic [3:0]  wall_y_q;
  logic        hit_q;

  logic [3:0]  sw_sync;
  dir_t        dir_sel;
  logic signed [5:0] tgt_x;
  logic signed [4:0] tgt_y;
  logic        tgt_ok;
  logic [4:0]  new_x_d;
  logic [3:0]  new_y_d;
  logic        at_goal_d;

  sync2 #(.WIDTH(4)) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (dir_sw),
    .q_o   (sw_sync)
  );

  // Target carries one extra sign bit so a step off either edge shows up as out of range instead of wrapping.
  always_comb begin
    dir_sel = pick_dir(sw_sync);
    tgt_x   = $signed({1'b0, px_q});
    tgt_y   = $signed({1'b0, py_q});
    case (dir_sel)
      DIR_UP:    tgt_y = $signed({1'b0, py_q}) - 5'sd1;
      DIR_DOWN:  tgt_y = $signed({1'b0, py_q}) + 5'sd1;
      DIR_LEFT:  tgt_x = $signed({1'b0, px_q}) - 6'sd1;
      DIR_RIGHT: tgt_x = $signed({1'b0, px_q}) + 6'sd1;
      default: ;
    endcase
    tgt_ok = (dir_sel != DIR_NONE) &&
             (int'(tgt_x) >= 0) && (int'(tgt_x) < COLS) &&
             (int'(tgt_y) >= 0) && (int'(tgt_y) < ROWS);

    new_x_d   = hit_q ? px_q : wall_x_q;
    new_y_d   = hit_q ? py_q : wall_y_q;
    at_goal_d = (new_x_d == 5'(GOAL_X)) && (new_y_d == 4'(GOAL_Y));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      px_q      <= 5'(START_X);
      py_q      <= 4'(START_Y);
      moves_q   <= '0;
      win_q     <= 1'b0;
      busy_q    <= 1'b0;
      wall_rd_q <= 1'b0;
      wall_x_q  <= '0;
      wall_y_q  <= '0;
      hit_q     <= 1'b0;
    end else begin
      wall_rd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick && tgt_ok) begin
            state_q   <= ST_LOOKUP;
            busy_q    <= 1'b1;
            wall_rd_q <= 1'b1;
            wall_x_q  <= tgt_x[4:0];
            wall_y_q  <= tgt_y[3:0];
          end
        end
        ST_LOOKUP: state_q <= ST_WAIT;
        // ROM data is only guaranteed valid in the cycle after the strobe, so grab it here.
        ST_WAIT: begin
          hit_q   <= wall_q;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          busy_q <= 1'b0;
          px_q   <= new_x_d;
          py_q   <= new_y_d;
          if (!hit_q && (moves_q != 10'd1023)) moves_q <= moves_q + 10'd1;
          if (at_goal_d) begin
            state_q <= ST_WON;
            win_q   <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WON: state_q <= ST_WON;
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wall_rd  = wall_rd_q;
  assign wall_x   = wall_x_q;
  assign wall_y   = wall_y_q;
  assign player_x = px_q;
  assign player_y = py_q;
  assign busy     = busy_q;
  assign win      = win_q;
  assign moves    = moves_q;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed bench for maze_player_ctrl: ROM model has walls only on row 0.
module tb_maze_player_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] dir_sw = 4'b0000;
  logic       wall_rd;
  logic [4:0] wall_x;
  logic [3:0] wall_y;
  logic       wall_q = 1'b0;
  logic [4:0] player_x;
  logic [3:0] player_y;
  logic       busy;
  logic       win;
  logic [9:0] moves;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int rd0 = 0;
  logic busy_seen = 1'b0;

  maze_player_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .dir_sw     (dir_sw),
    .wall_rd    (wall_rd),
    .wall_x     (wall_x),
    .wall_y     (wall_y),
    .wall_q     (wall_q),
    .player_x   (player_x),
    .player_y   (player_y),
    .busy       (busy),
    .win        (win),
    .moves      (moves)
  );

  always #5 clk = ~clk;

  always @(posedge clk) wall_q <= wall_rd ? (wall_y == 4'd0) : 1'b0;

  always @(posedge clk) if (rst_n && wall_rd) rd_cnt <= rd_cnt + 1;

  always @(negedge clk) if (busy) busy_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic move(input logic [3:0] sw, input int n);
    dir_sw = sw;
    step(3);
    repeat (n) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(6);
    end
  endtask

  task automatic chk_pos(input string tag, input int x, input int y, input int m);
    chk({tag, "_x"}, 32'(player_x), x);
    chk({tag, "_y"}, 32'(player_y), y);
    chk({tag, "_moves"}, 32'(moves), m);
  endtask

  initial begin
    // Reset state, checked while reset is still held.
    step(2);
    chk_pos("rst", 1, 1, 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wall_rd", 32'(wall_rd), 0);
    chk("rst_wall_x", 32'(wall_x), 0);
    chk("rst_wall_y", 32'(wall_y), 0);
    rst_n = 1'b1;
    step(2);
    chk_pos("rel", 1, 1, 0);
    chk("rel_busy", 32'(busy), 0);

    // Up into the row-0 wall.
    dir_sw = 4'b1000;
    step(3);
    rd0 = rd_cnt;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("up_rd", 32'(wall_rd), 1);
    chk("up_wx", 32'(wall_x), 1);
    chk("up_wy", 32'(wall_y), 0);
    chk("up_busy", 32'(busy), 1);
    step(3);
    chk_pos("up_wall", 1, 1, 0);
    chk("up_rd_cnt", 32'(rd_cnt - rd0), 1);
    chk("up_busy_done", 32'(busy), 0);

    // Right with per-cycle latency check, then two more.
    dir_sw = 4'b0001;
    step(3);
    rd0 = rd_cnt;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("r_lookup_rd", 32'(wall_rd), 1);
    chk("r_lookup_wx", 32'(wall_x), 2);
    step(1);
    chk("r_wait_rd", 32'(wall_rd), 0);
    step(1);
    chk("r_check_x", 32'(player_x), 1);
    step(1);
    chk("r_upd_x", 32'(player_x), 2);
    chk("r_upd_busy", 32'(busy), 0);
    step(2);
    move(4'b0001, 2);
    chk_pos("r3", 4, 1, 3);
    chk("r3_rd_cnt", 32'(rd_cnt - rd0), 3);

    // To the right edge and down to row 5.
    move(4'b0001, 15);
    move(4'b0100, 4);
    chk_pos("edge", 19, 5, 22);

    // All switches: up wins; a second tick two cycles later is dropped.
    dir_sw = 4'b1111;
    step(3);
    rd0 = rd_cnt;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(1);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(8);
    chk_pos("prio", 19, 4, 23);
    chk("prio_rd_cnt", 32'(rd_cnt - rd0), 1);

    // Down beats left.
    move(4'b0110, 1);
    chk_pos("prio2", 19, 5, 24);

    // Right off the right edge is dropped.
    dir_sw = 4'b0001;
    step(3);
    rd0 = rd_cnt;
    busy_seen = 1'b0;
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    step(6);
    chk_pos("oob_r", 19, 5, 24);
    chk("oob_r_rd", 32'(rd_cnt - rd0), 0);
    chk("oob_r_busy", 32'(busy_seen), 0);

    // Across to column 0, then left off the left edge is dropped.
    move(4'b0010, 19);
    chk_pos("col0", 0, 5, 43);
    rd0 = rd_cnt;
    busy_seen = 1'b0;
    move(4'b0010, 1);
    chk_pos("oob_l", 0, 5, 43);
    chk("oob_l_rd", 32'(rd_cnt - rd0), 0);
    chk("oob_l_busy", 32'(busy_seen), 0);

    // Walk to the goal.
    move(4'b0001, 18);
    move(4'b0100, 7);
    chk_pos("near", 18, 12, 68);
    chk("near_win", 32'(win), 0);
    move(4'b0100, 1);
    chk_pos("goal", 18, 13, 69);
    chk("goal_win", 32'(win), 1);
    chk("goal_busy", 32'(busy), 0);

    // Frozen in WON.
    rd0 = rd_cnt;
    move(4'b1000, 3);
    chk_pos("won", 18, 13, 69);
    chk("won_rd", 32'(rd_cnt - rd0), 0);
    chk("won_win", 32'(win), 1);

    // Reset leaves WON.
    rst_n = 1'b0;
    #1;
    chk_pos("rst2", 1, 1, 0);
    chk("rst2_win", 32'(win), 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Reset in LOOKUP aborts the move.
    dir_sw = 4'b0001;
    step(3);
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
    chk("abort_lookup_rd", 32'(wall_rd), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rd", 32'(wall_rd), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wx", 32'(wall_x), 0);
    step(1);
    rst_n = 1'b1;
    step(6);
    chk_pos("abort", 1, 1, 0);
    chk("abort_win", 32'(win), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
